// File: rtl/mem_arbiter.sv
// Two-port whole-line arbiter in front of the 256-bit Data_Memory port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build uses fixed priority (port 0 wins).
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              err_o,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, GAP} state_t;

    // A TIMEOUT beyond the counter range can only be met at saturation.
    localparam logic [6:0] TIMEOUT_C = (TIMEOUT > 127) ? 7'h7F : 7'(TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [6:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       tie1_s;
    logic       pick0_s;

`ifdef MEM_ARB_RR_EN
    logic       last_q, last_d;
    assign tie1_s = ~last_q;
`else
    assign tie1_s = 1'b0;
`endif

    assign pick0_s = m0_enable_i & ~(m1_enable_i & tie1_s);

    // Next-state, grant, timeout counter and sticky error
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick0_s) begin
                    state_d = BUSY0;
                    grant_d = 2'b01;
                    cnt_d   = 7'd0;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b0;
`endif
                end else if (m1_enable_i) begin
                    state_d = BUSY1;
                    grant_d = 2'b10;
                    cnt_d   = 7'd0;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY0, BUSY1: begin
                if (mem_ack_i) begin
                    state_d = GAP;
                    grant_d = 2'b00;
                end else begin
                    if (cnt_q != 7'h7F) begin
                        cnt_d = cnt_q + 7'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    // The transaction is flagged but keeps waiting for its ack.
                    if (cnt_d >= TIMEOUT_C) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State and registered status flops
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= 7'd0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Memory request mux and ack steering follow the granted port
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = {ADDR_W{1'b0}};
        mem_data_o   = {DATA_W{1'b0}};
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        case (state_q)
            BUSY0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                m0_ack_o     = mem_ack_i;
            end
            BUSY1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                m1_ack_o     = mem_ack_i;
            end
            default: begin
                mem_enable_o = 1'b0;
            end
        endcase
    end

    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;
    assign grant_o   = grant_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester and memory models, per-port scoreboard queues.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          en [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] m0_data, m1_data;
    logic          m0_ack, m1_ack;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err_o;
    logic [1:0]    grant_o;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_enable_i(en[0]), .m0_write_i(wr[0]), .m0_addr_i(ad[0]), .m0_data_i(wd[0]),
        .m0_data_o(m0_data), .m0_ack_o(m0_ack),
        .m1_enable_i(en[1]), .m1_write_i(wr[1]), .m1_addr_i(ad[1]), .m1_data_i(wd[1]),
        .m1_data_o(m1_data), .m1_ack_o(m1_ack),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .err_o(err_o), .grant_o(grant_o)
    );

    typedef struct { logic wr; logic [DW-1:0] data; } exp_t;
    typedef struct {
        int port; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int dly; logic [DW-1:0] rdata;
    } vec_t;

    exp_t    q0[$];
    exp_t    q1[$];
    int      order_q[$];
    logic [DW-1:0] mem [64];
    int      mem_cnt, mem_delay;
    bit      mem_noack, force_ack, stray;
    bit      drop [2];
    int      pend [2];
    int      acks_seen [2];
    int      errors, checks;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic failmsg(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s at %0t", nm, what, $time);
    endtask

    task automatic clear_tb();
        for (int p = 0; p < 2; p++) begin
            en[p] = 1'b0; drop[p] = 1'b0; pend[p] = 0;
        end
        q0.delete(); q1.delete(); order_q.delete();
        mem_cnt = 0; mem_noack = 1'b0; force_ack = 1'b0; stray = 1'b0; mem_ack = 1'b0;
    endtask

    // One clock cycle: requesters update, memory responds, outputs are observed.
    task automatic step();
        logic [1:0] acks_v;
        exp_t e;
        bit ok;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (drop[p]) begin
                en[p] = 1'b0; drop[p] = 1'b0;
            end else if (!en[p] && pend[p] > 0) begin
                en[p] = 1'b1; pend[p]--;
            end
        end
        #1;
        if (stray) begin
            mem_ack = 1'b1; stray = 1'b0;
        end else if (mem_enable_o) begin
            mem_cnt++;
            if (force_ack || (!mem_noack && mem_cnt > mem_delay)) begin
                mem_ack = 1'b1; force_ack = 1'b0; mem_cnt = 0;
                if (mem_write_o) mem[mem_addr_o[10:5]] = mem_data_o;
                else mem_rdata = mem[mem_addr_o[10:5]];
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_cnt = 0; mem_ack = 1'b0;
        end
        #1;
        acks_v = {m1_ack, m0_ack};
        if (grant_o == 2'b00)
            chk("idle_quiet", {250'b0, mem_enable_o, mem_write_o, |mem_addr_o, |mem_data_o, m0_ack, m1_ack}, 256'd0);
        if (acks_v == 2'b11) failmsg("dual_ack", "got both acks, expected at most one");
        for (int p = 0; p < 2; p++) begin
            if (acks_v[p]) begin
                ok = 1'b1;
                chk("ack_grant", 256'(grant_o[p]), 256'd1);
                if (p == 0) begin
                    if (q0.size() == 0) begin failmsg("spurious_ack0", "got ack, expected none"); ok = 1'b0; end
                    else e = q0.pop_front();
                end else begin
                    if (q1.size() == 0) begin failmsg("spurious_ack1", "got ack, expected none"); ok = 1'b0; end
                    else e = q1.pop_front();
                end
                if (ok && !e.wr) chk("rdata", (p == 0) ? m0_data : m1_data, e.data);
                if (order_q.size() > 0) chk("grant_order", 256'(p), 256'(order_q.pop_front()));
                drop[p] = 1'b1;
                acks_seen[p]++;
            end
        end
    endtask

    task automatic push_exp(input int p, input logic w, input logic [DW-1:0] d);
        exp_t e;
        e.wr = w; e.data = d;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly, input logic [DW-1:0] exp_r);
        int start;
        bit seen_busy;
        logic [1:0] g;
        g = (p == 0) ? 2'b01 : 2'b10;
        mem_delay = dly; wr[p] = w; ad[p] = a; wd[p] = d;
        push_exp(p, w, exp_r);
        pend[p] = 1; start = acks_seen[p]; seen_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!seen_busy && grant_o != 2'b00) begin
                seen_busy = 1'b1;
                chk("busy_grant", 256'(grant_o), 256'(g));
                chk("busy_enable", 256'(mem_enable_o), 256'd1);
                chk("busy_addr", 256'(mem_addr_o), 256'(a));
                chk("busy_write", 256'(mem_write_o), 256'(w));
                if (w) chk("busy_wdata", mem_data_o, d);
            end
            if (acks_seen[p] != start && grant_o == 2'b00 && !en[p]) break;
        end
        if (acks_seen[p] == start) failmsg("txn_timeout", "got no ack in 100 cycles, expected one");
        chk("grant_after", 256'(grant_o), 256'd0);
    endtask

    task automatic do_reset();
        clear_tb();
        rst = 1'b0;
        step(); step();
        chk("rst_err", 256'(err_o), 256'd0);
        chk("rst_grant", 256'(grant_o), 256'd0);
        rst = 1'b1;
        step();
    endtask

    initial begin
        vec_t vecs[6];
        int start0, start1, busy_n, a;
        logic en_hist[64];
        int ack_at[$];

        errors = 0; checks = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            wr[p] = 1'b0; ad[p] = '0; wd[p] = '0; acks_seen[p] = 0;
        end
        clear_tb();
        mem_rdata = '0; mem_delay = 0;
        rst = 1'b0;

        // Outputs stay quiet under reset even with a request and an ack present.
        en[0] = 1'b1; mem_ack = 1'b1;
        #2;
        chk("reset_grant", 256'(grant_o), 256'd0);
        chk("reset_err", 256'(err_o), 256'd0);
        chk("reset_enable", 256'(mem_enable_o), 256'd0);
        chk("reset_ack", 256'({m0_ack, m1_ack}), 256'd0);
        chk("reset_addr", 256'(mem_addr_o), 256'd0);
        en[0] = 1'b0; mem_ack = 1'b0;
        step(); step();
        rst = 1'b1;
        step();

        vecs[0] = '{1, 1'b1, 32'h400, 256'hA5, 3, 256'h0};
        vecs[1] = '{0, 1'b0, 32'h400, 256'h0,  2, 256'hA5};
        vecs[2] = '{0, 1'b1, 32'h020, 256'h5,  1, 256'h0};
        vecs[3] = '{1, 1'b0, 32'h020, 256'h0,  4, 256'h5};
        vecs[4] = '{0, 1'b0, 32'h7E0, 256'h0,  0, 256'h0};
        vecs[5] = '{0, 1'b0, 32'h020, 256'h0, 10, 256'h5};
        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].rdata);
            chk("err_after", 256'(err_o), (vecs[i].dly >= 8) ? 256'd1 : 256'd0);
        end
        chk("mem32", mem[32], 256'hA5);

        // Timeout: no ack from memory, then a late ack completes the transaction.
        do_reset();
        mem_noack = 1'b1; wr[0] = 1'b0; ad[0] = 32'h20;
        push_exp(0, 1'b0, 256'h5);
        pend[0] = 1; start0 = acks_seen[0]; busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (grant_o != 2'b00) begin
                busy_n++;
                if (busy_n == 7) chk("err_early", 256'(err_o), 256'd0);
                if (busy_n == 9) chk("err_set", 256'(err_o), 256'd1);
                if (busy_n == 20) begin chk("err_hold", 256'(err_o), 256'd1); force_ack = 1'b1; end
            end
            if (acks_seen[0] != start0) break;
        end
        if (acks_seen[0] == start0) failmsg("late_ack", "got no completion, expected late ack to complete");
        step();
        chk("err_sticky", 256'(err_o), 256'd1);
        chk("late_grant", 256'(grant_o), 256'd0);

        // Both ports requesting continuously.
        do_reset();
        mem_delay = 1; wr[0] = 1'b0; wr[1] = 1'b0; ad[0] = 32'h400; ad[1] = 32'h400;
        start0 = acks_seen[0]; start1 = acks_seen[1];
`ifdef MEM_ARB_RR_EN
        order_q = '{0, 1, 0, 1};
        for (int k = 0; k < 2; k++) begin push_exp(0, 1'b0, 256'hA5); push_exp(1, 1'b0, 256'hA5); end
        pend[0] = 2; pend[1] = 2;
        for (int i = 0; i < 200; i++) begin
            step();
            if (acks_seen[0] - start0 + acks_seen[1] - start1 == 4) break;
        end
        chk("rr_count0", 256'(acks_seen[0] - start0), 256'd2);
        chk("rr_count1", 256'(acks_seen[1] - start1), 256'd2);
`else
        order_q = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) push_exp(0, 1'b0, 256'hA5);
        push_exp(1, 1'b0, 256'hA5);
        pend[0] = 4; pend[1] = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (acks_seen[0] - start0 == 4) break;
        end
        chk("fp_count0", 256'(acks_seen[0] - start0), 256'd4);
        chk("fp_starve1", 256'(acks_seen[1] - start1), 256'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (acks_seen[1] != start1) break;
        end
        chk("fp_late1", 256'(acks_seen[1] - start1), 256'd1);
`endif
        chk("order_done", 256'(order_q.size()), 256'd0);
        step(); step();

        // Back-to-back port-0 requests: ack, GAP, IDLE, then the next grant.
        mem_delay = 1; ad[0] = 32'h20;
        push_exp(0, 1'b0, 256'h5); push_exp(0, 1'b0, 256'h5);
        pend[0] = 2;
        for (int i = 0; i < 64; i++) begin
            step();
            en_hist[i] = mem_enable_o;
            if (m0_ack) ack_at.push_back(i);
        end
        chk("b2b_acks", 256'(ack_at.size()), 256'd2);
        if (ack_at.size() > 0 && ack_at[0] < 60) begin
            a = ack_at[0];
            chk("gap_enable", 256'(en_hist[a+1]), 256'd0);
            chk("idle_enable", 256'(en_hist[a+2]), 256'd0);
            chk("regrant_enable", 256'(en_hist[a+3]), 256'd1);
        end

        // A stray ack while idle must not be forwarded or change state.
        stray = 1'b1;
        step();
        step();
        chk("stray_state", 256'(grant_o), 256'd0);

        // Reset pulled in the middle of a port-1 transaction.
        mem_noack = 1'b1; wr[1] = 1'b1; ad[1] = 32'h40; wd[1] = 256'h77;
        push_exp(1, 1'b1, 256'h0);
        pend[1] = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_o == 2'b10) break;
        end
        chk("mid_grant", 256'(grant_o), 256'd2);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_enable", 256'(mem_enable_o), 256'd0);
        chk("mid_rst_grant", 256'(grant_o), 256'd0);
        chk("mid_rst_ack", 256'(m1_ack), 256'd0);
        clear_tb();
        step(); step();
        rst = 1'b1;
        step();
        txn(0, 1'b0, 32'h400, 256'h0, 2, 256'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
